misao_fetch: RTL and testbench
==============================

# misao_fetch

Nibble prefetch queue between the byte-wide program memory and the MISA-O decode/execute core. It issues byte reads ahead of execution, splits each byte into two nibbles (low nibble = even nibble address), and presents one nibble per cycle to the core over a valid/ready handshake. On a control-flow redirect it flushes all buffered and in-flight nibbles and restarts from the new nibble-addressed PC.

## Interface
- `DEPTH`, 8: nibble queue capacity; power of two, ≥4.
- `RESET_PC`, 16'h0002: nibble address fetched first after reset.

- `clk` in 1: the single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_enable_read` out 1: read request strobe, one byte per asserted cycle.
- `mem_addr` out 15: byte address of the request (nibble PC >> 1).
- `mem_data_in` in 8: read data, valid the cycle after the request cycle.
- `redirect` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in 16: new nibble address.
- `nib_valid` out 1: head nibble available.
- `nib_ready` in 1: core consumes head nibble this cycle.
- `nib_data` out 4: head nibble.
- `nib_pc` out 16: nibble address of head nibble.

## Operation
- State: `fetch_pc[15:0]` (next nibble address to request), queue of DEPTH entries {data[3:0]}, `head_pc[15:0]`, `count`, `inflight` (0/1 byte pending), `drop_low` flag.
- Request rule: `mem_enable_read`=1 in a cycle iff free slots ≥ 2 + 2·inflight (credit includes byte returning this cycle) and no redirect sampled at the preceding edge is being applied. `mem_addr`=`fetch_pc[15:1]`; `fetch_pc` += 2 (aligned to even) per request.
- Return: data of a request issued in cycle R is sampled at end of R+1; low nibble then high nibble pushed. If `drop_low` is set for that byte (odd redirect target), only the high nibble is pushed and `drop_low` clears.
- Pop: `nib_valid && nib_ready` removes head; `head_pc` += 1 (wraps 16'hFFFF→0).
- Simultaneous push and pop in one cycle allowed; count updates by net difference. Queue never overflows by credit rule; overflow is a design error (assertion).
- Redirect (sampled at posedge): queue emptied, `count`=0, in-flight return discarded (kill flag on the pending byte), `fetch_pc`=`redirect_pc`, `head_pc`=`redirect_pc`, `drop_low`=`redirect_pc[0]`. Redirect beats a same-cycle pop: pop ignored. Redirect beats same-cycle return: byte discarded.
- Back-to-back redirects: last one wins; each discards everything before it.
- `fetch_pc` wraps 16'hFFFE→0; `mem_addr` wraps accordingly.
- Reset (`rst`=0, any time): `mem_enable_read`=0, `mem_addr`=0, `nib_valid`=0, `nib_data`=0, `nib_pc`=RESET_PC, queue empty, inflight=0, `fetch_pc`=RESET_PC, `drop_low`=RESET_PC[0]. Mid-fetch reset drops the pending byte.

## Timing
- `nib_valid`, `nib_data`, `nib_pc` are registered (driven from queue head), no combinational path from `nib_ready`.
- `mem_enable_read`/`mem_addr` are registered.
- Reset release before edge E0: request in cycle after E0 (C1); data sampled end of C2; `nib_valid`=1 in C3.
- Redirect sampled at edge E: request cycle E+1, `nib_valid` cycle E+3; odd target gives same latency (high nibble only).
- Steady state: with `nib_ready` held 1, `nib_valid` stays 1 continuously (2 nibbles/request, one request per ≤2 cycles).
- Queue full with `nib_ready`=0: no requests issued; resumes the cycle after credit frees.

## Structure
- Shared package `misao_pkg`: RESET_PC default constant, nibble/byte/PC width localparams, link-mode constants shared with the core.
- One sub-module: `misao_nib_fifo` (DEPTH-entry nibble FIFO, 2-push/1-pop per cycle, count output). Top holds fetch/credit/redirect logic.

## Test plan
- Reset then `nib_ready`=1, memory byte1=8'hBA, byte2=8'hDC: nibble stream A,B,C,D with `nib_pc` 2,3,4,5; first `nib_valid` 3 cycles after reset release.
- `nib_ready`=0 forever: exactly DEPTH nibbles buffered, `mem_enable_read` stops; then ready=1 yields DEPTH+ contiguous nibbles with no gap or duplicate.
- Redirect to 16'h0011 while byte in flight: stale byte discarded; first nibble = byte 8 high nibble, `nib_pc`=16'h0011.
- Redirect and `nib_ready`=1 same cycle: head not consumed twice, next nibble comes from new target.
- `fetch_pc` near 16'hFFFE: `mem_addr` 15'h7FFF then 0, `nib_pc` FFFE, FFFF, 0000.
- Assert `rst` mid-stream with count=5: all outputs at reset values next cycle; restart at RESET_PC.

Source files
------------

// File: rtl/misao_pkg.sv
// Shared MISA-O definitions: datapath widths, reset fetch address and the
// link-mode encoding used between the fetch unit and the core.
package misao_pkg;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PC_W   = 16;
  localparam int unsigned ADDR_W = PC_W - 1;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0002;

  typedef enum logic [1:0] {
    LINK_NONE = 2'd0,
    LINK_CALL = 2'd1,
    LINK_RET  = 2'd2,
    LINK_JUMP = 2'd3
  } link_mode_e;

  // Nibble address of the byte following the one containing pc (always even).
  function automatic logic [PC_W-1:0] next_byte_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:1] + 1'b1, 1'b0};
  endfunction
endpackage

// File: rtl/misao_fetch_if.sv
// Fetch-unit bus bundle: program-memory read port, redirect input and the
// nibble valid/ready stream toward the core.
interface misao_fetch_if;
  import misao_pkg::*;

  logic                mem_enable_read;
  logic [ADDR_W-1:0]   mem_addr;
  logic [BYTE_W-1:0]   mem_data_in;
  logic                redirect;
  logic [PC_W-1:0]     redirect_pc;
  logic                nib_valid;
  logic                nib_ready;
  logic [NIB_W-1:0]    nib_data;
  logic [PC_W-1:0]     nib_pc;

  modport master (
    output mem_enable_read, mem_addr, nib_valid, nib_data, nib_pc,
    input  mem_data_in, redirect, redirect_pc, nib_ready
  );

  modport slave (
    input  mem_enable_read, mem_addr, nib_valid, nib_data, nib_pc,
    output mem_data_in, redirect, redirect_pc, nib_ready
  );
endinterface

// File: rtl/misao_nib_fifo.sv
// Nibble FIFO accepting up to two nibbles and releasing one per cycle;
// head and occupancy come straight from registers.
module misao_nib_fifo
  import misao_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               push_cnt,
  input  logic [NIB_W-1:0]         push_w0,
  input  logic [NIB_W-1:0]         push_w1,
  input  logic                     pop,
  output logic [NIB_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [NIB_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             pop_ok;

  assign pop_ok = pop && (cnt != '0);
  assign head   = mem[rd_ptr];
  assign count  = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      ovf_check: assert ((int'(cnt) + int'(push_cnt) - int'(pop_ok)) <= int'(DEPTH));
      if (push_cnt != 2'd0) mem[wr_ptr] <= push_w0;
      if (push_cnt == 2'd2) mem[wr_ptr + 1'b1] <= push_w1;
      wr_ptr <= wr_ptr + AW'(push_cnt);
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_cnt) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/misao_fetch.sv
// MISA-O nibble prefetch: credit-limited byte reads, nibble split, redirect
// flush, and a registered nibble stream toward the decode/execute core.
module misao_fetch
  import misao_pkg::*;
#(
  parameter int unsigned      DEPTH    = 8,
  parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEF
) (
  input  logic           clk,
  input  logic           rst,
  misao_fetch_if.master  bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]   fetch_pc, head_pc;
  logic [ADDR_W-1:0] addr;
  logic              req, ret_pending, drop_low;
  logic [CW-1:0]     fifo_count, count_next;
  logic [1:0]        push_cnt;
  logic [NIB_W-1:0]  push_w0, push_w1, head_nib;
  logic              pop, nib_valid, credit_ok;

  assign nib_valid = (fifo_count != '0);

  always_comb begin
    pop      = nib_valid && bus.nib_ready && !bus.redirect;
    push_cnt = 2'd0;
    push_w0  = bus.mem_data_in[NIB_W-1:0];
    push_w1  = bus.mem_data_in[BYTE_W-1:NIB_W];
    if (ret_pending && !bus.redirect) begin
      if (drop_low) begin
        push_cnt = 2'd1;
        push_w0  = bus.mem_data_in[BYTE_W-1:NIB_W];
      end else begin
        push_cnt = 2'd2;
      end
    end
    count_next = fifo_count + CW'(push_cnt) - CW'(pop);
    // Room must remain for the byte requested this cycle plus the new one.
    credit_ok  = (int'(count_next) + (req ? 4 : 2)) <= int'(DEPTH);
  end

  misao_nib_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect),
    .push_cnt (push_cnt),
    .push_w0  (push_w0),
    .push_w1  (push_w1),
    .pop      (pop),
    .head     (head_nib),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      drop_low    <= RESET_PC[0];
      req         <= 1'b0;
      addr        <= '0;
      ret_pending <= 1'b0;
    end else if (bus.redirect) begin
      // Clearing ret_pending kills the byte returning next cycle.
      fetch_pc    <= bus.redirect_pc;
      head_pc     <= bus.redirect_pc;
      drop_low    <= bus.redirect_pc[0];
      req         <= 1'b0;
      ret_pending <= 1'b0;
    end else begin
      ret_pending <= req;
      if (ret_pending) drop_low <= 1'b0;
      if (pop) head_pc <= head_pc + 1'b1;
      req <= credit_ok;
      if (credit_ok) begin
        addr     <= fetch_pc[PC_W-1:1];
        fetch_pc <= next_byte_pc(fetch_pc);
      end
    end
  end

  assign bus.mem_enable_read = req;
  assign bus.mem_addr        = addr;
  assign bus.nib_valid       = nib_valid;
  assign bus.nib_data        = head_nib;
  assign bus.nib_pc          = head_pc;
endmodule

// File: tb/tb_misao_fetch.sv
// Directed bench for misao_fetch: memory whose nibble at address n is n[3:0]+8
// (byte 1 = BA, byte 2 = DC), sampled on the falling clock edge.
module tb_misao_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  misao_fetch_if bus();

  misao_fetch #(.DEPTH(8), .RESET_PC(16'h0002)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int ncmp = 0;
  int nerr = 0;
  int nreq;

  function automatic logic [3:0] nib_at(input logic [15:0] pc);
    return pc[3:0] + 4'h8;
  endfunction

  function automatic logic [7:0] byte_at(input logic [14:0] a);
    return {nib_at({a, 1'b1}), nib_at({a, 1'b0})};
  endfunction

  always @(posedge clk)
    if (bus.mem_enable_read) bus.mem_data_in <= byte_at(bus.mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_nib(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, 32'(bus.nib_valid), 32'd1);
    check({tag, "_pc"},    32'(bus.nib_pc),    32'(pc));
    check({tag, "_data"},  32'(bus.nib_data),  32'(nib_at(pc)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(bus.mem_enable_read), 32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr),        32'd0);
    check({tag, "_valid"}, 32'(bus.nib_valid),       32'd0);
    check({tag, "_data"},  32'(bus.nib_data),        32'd0);
    check({tag, "_pc"},    32'(bus.nib_pc),          32'h0002);
  endtask

  // Drives a one-cycle redirect; returns at the first falling edge after it is sampled.
  task automatic redirect_pulse(input logic [15:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    @(negedge clk);
    bus.redirect    = 1'b0;
  endtask

  task automatic expect_after_redirect(input string tag, input logic [15:0] pc);
    check({tag, "_n1_req"},   32'(bus.mem_enable_read), 32'd0);
    check({tag, "_n1_valid"}, 32'(bus.nib_valid),       32'd0);
    @(negedge clk);
    check({tag, "_n2_req"},   32'(bus.mem_enable_read), 32'd1);
    check({tag, "_n2_addr"},  32'(bus.mem_addr),        32'(pc[15:1]));
    check({tag, "_n2_valid"}, 32'(bus.nib_valid),       32'd0);
    @(negedge clk);
    check({tag, "_n3_valid"}, 32'(bus.nib_valid),       32'd0);
    @(negedge clk);
    check_nib({tag, "_first"}, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.nib_ready   = 1'b1;

    // Reset state and first-fetch latency
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);
    check("c1_req",   32'(bus.mem_enable_read), 32'd1);
    check("c1_addr",  32'(bus.mem_addr),        32'd1);
    check("c1_valid", 32'(bus.nib_valid),       32'd0);
    @(negedge clk);
    check("c2_req",   32'(bus.mem_enable_read), 32'd1);
    check("c2_addr",  32'(bus.mem_addr),        32'd2);
    check("c2_valid", 32'(bus.nib_valid),       32'd0);
    @(negedge clk);
    check("c3_valid", 32'(bus.nib_valid), 32'd1);
    check("c3_data",  32'(bus.nib_data),  32'hA);
    check("c3_pc",    32'(bus.nib_pc),    32'h2);
    @(negedge clk);
    check("c4_data", 32'(bus.nib_data), 32'hB);
    check("c4_pc",   32'(bus.nib_pc),   32'h3);
    @(negedge clk);
    check("c5_data", 32'(bus.nib_data), 32'hC);
    check("c5_pc",   32'(bus.nib_pc),   32'h4);
    @(negedge clk);
    check("c6_data", 32'(bus.nib_data), 32'hD);
    check("c6_pc",   32'(bus.nib_pc),   32'h5);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_nib("stream", 16'(6 + i));
    end

    // Consumer stalled: queue fills to DEPTH and requests stop
    bus.nib_ready = 1'b0;
    redirect_pulse(16'h0020);
    nreq = 0;
    for (int k = 0; k < 14; k++) begin
      if (bus.mem_enable_read) nreq++;
      @(negedge clk);
    end
    check("full_nreq", 32'(nreq), 32'd4);
    check("full_req",  32'(bus.mem_enable_read), 32'd0);
    check_nib("full_head", 16'h0020);
    bus.nib_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check_nib("drain", 16'(16'h0020 + k));
      @(negedge clk);
    end

    // Redirect to an odd target while a byte is in flight
    for (int k = 0; k < 8 && !bus.mem_enable_read; k++) @(negedge clk);
    check("inflight_req", 32'(bus.mem_enable_read), 32'd1);
    redirect_pulse(16'h0011);
    expect_after_redirect("odd", 16'h0011);
    @(negedge clk);
    check_nib("odd_next", 16'h0012);

    // Back-to-back redirects with the consumer ready: the later target wins
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0055;
    @(negedge clk);
    bus.redirect_pc = 16'h0040;
    @(negedge clk);
    bus.redirect    = 1'b0;
    expect_after_redirect("b2b", 16'h0040);
    @(negedge clk);
    check_nib("b2b_next", 16'h0041);

    // Fetch address wrap at the top of memory
    redirect_pulse(16'hFFFE);
    check("wrap_n1_req", 32'(bus.mem_enable_read), 32'd0);
    @(negedge clk);
    check("wrap_n2_req",  32'(bus.mem_enable_read), 32'd1);
    check("wrap_n2_addr", 32'(bus.mem_addr),        32'h7FFF);
    @(negedge clk);
    check("wrap_n3_req",  32'(bus.mem_enable_read), 32'd1);
    check("wrap_n3_addr", 32'(bus.mem_addr),        32'h0000);
    @(negedge clk);
    check_nib("wrap_a", 16'hFFFE);
    @(negedge clk);
    check_nib("wrap_b", 16'hFFFF);
    @(negedge clk);
    check_nib("wrap_c", 16'h0000);

    // Reset mid-stream: five nibbles queued and a byte returning
    bus.nib_ready = 1'b0;
    redirect_pulse(16'h0061);
    repeat (3) @(negedge clk);
    check_nib("pre_rst_head", 16'h0061);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    bus.nib_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("re_c1_req",  32'(bus.mem_enable_read), 32'd1);
    check("re_c1_addr", 32'(bus.mem_addr),        32'd1);
    @(negedge clk);
    check("re_c2_valid", 32'(bus.nib_valid), 32'd0);
    @(negedge clk);
    check_nib("re_c3", 16'h0002);
    @(negedge clk);
    check_nib("re_c4", 16'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
